// File: rtl/decoder_pkg.sv
// Shared types and helpers for the pulse-sequencing binary decoder.
// Consumers: decoder_pulse_seq and its bench.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } dec_state_t;

    localparam int HIT_CNT_W = 16;

    // onehot_of is written for the widest supported code; callers truncate to their OUT_W.
    localparam int MAX_IN_W  = 8;
    localparam int MAX_OUT_W = 2 ** MAX_IN_W;

    function automatic logic [MAX_OUT_W-1:0] onehot_of(input logic [MAX_IN_W-1:0] code);
        logic [MAX_OUT_W-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dec_down_counter.sv
// Loadable down-counter with a zero flag; stops at zero instead of wrapping.
module dec_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/decoder_pulse_seq.sv
// Sequential N-to-2^N decoder: one-hot pulse of programmable length, then an idle gap.
// Optional macro DECODER_HIT_CNT_EN adds a saturating 16-bit accepted-code counter (hit_count).
module decoder_pulse_seq
    import decoder_pkg::*;
#(
    parameter  int IN_W  = 2,
    parameter  int CNT_W = 8,
    localparam int OUT_W = 2 ** IN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_code,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] pulse_len,
    input  logic [CNT_W-1:0] gap_len,
    output logic [OUT_W-1:0] out,
    output logic             busy,
    output logic             done
`ifdef DECODER_HIT_CNT_EN
    ,
    output logic [HIT_CNT_W-1:0] hit_count
`endif
);

    // Handshake: a code is taken on a rising edge with in_valid && in_ready;
    // in_ready depends only on the state register, so it never follows in_valid.
    dec_state_t       state_q, state_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] glen_q, glen_d;
    logic             accept;
    logic             p_load, p_dec, p_zero;
    logic             g_load, g_dec, g_zero;
    logic [CNT_W-1:0] p_val, g_val;

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign accept   = in_valid && in_ready;
    assign out      = out_q;

    // A zero pulse length behaves as one cycle, so the load value never underflows.
    assign p_val = (pulse_len == '0) ? '0 : pulse_len - 1'b1;
    assign g_val = glen_q - 1'b1;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        glen_d  = glen_q;
        p_load  = 1'b0;
        p_dec   = 1'b0;
        g_load  = 1'b0;
        g_dec   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                out_d = '0;
                if (accept) begin
                    out_d   = OUT_W'(onehot_of(MAX_IN_W'(in_code)));
                    p_load  = 1'b1;
                    glen_d  = gap_len;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (p_zero) begin
                    done  = 1'b1;
                    out_d = '0;
                    if (glen_q != '0) begin
                        g_load  = 1'b1;
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    p_dec = 1'b1;
                end
            end
            GAP: begin
                out_d = '0;
                if (g_zero) begin
                    state_d = IDLE;
                end else begin
                    g_dec = 1'b1;
                end
            end
            default: begin
                out_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            glen_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            glen_q  <= glen_d;
        end
    end

    dec_down_counter #(.W(CNT_W)) u_pulse_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (p_load),
        .load_val (p_val),
        .dec      (p_dec),
        .zero     (p_zero)
    );

    dec_down_counter #(.W(CNT_W)) u_gap_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (g_load),
        .load_val (g_val),
        .dec      (g_dec),
        .zero     (g_zero)
    );

`ifdef DECODER_HIT_CNT_EN
    logic [HIT_CNT_W-1:0] hit_cnt_q, hit_cnt_d;

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (accept && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_count = hit_cnt_q;
`endif

endmodule

// File: tb/tb_decoder_pulse_seq.sv
// Directed bench for decoder_pulse_seq; hit_count checks compile in with DECODER_HIT_CNT_EN.
module tb_decoder_pulse_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] in_code;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] pulse_len;
    logic [7:0] gap_len;
    logic [3:0] out;
    logic       busy;
    logic       done;
`ifdef DECODER_HIT_CNT_EN
    logic [15:0] hit_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    decoder_pulse_seq #(.IN_W(2), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_code   (in_code),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pulse_len (pulse_len),
        .gap_len   (gap_len),
        .out       (out),
        .busy      (busy),
        .done      (done)
`ifdef DECODER_HIT_CNT_EN
        ,
        .hit_count (hit_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later, and check the one-hot-or-zero invariant.
    task automatic cyc();
        @(posedge clk);
        #1;
        chk("onehot0", 32'($onehot0(out)), 32'd1);
    endtask

    int n;
    int ndone;
    int done_at;

    initial begin
        rst_n     = 1'b0;
        in_code   = 2'd0;
        in_valid  = 1'b0;
        pulse_len = 8'd1;
        gap_len   = 8'd0;

        // Reset then idle
        repeat (3) cyc();
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("idle_out", 32'(out), 32'h0);

        // Full decode sweep with single-cycle pulses and no gap
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_code = 2'(c);
            chk("sweep_ready_idle", 32'(in_ready), 32'd1);
            cyc();
            chk("sweep_out", 32'(out), 32'(4'b0001 << c));
            chk("sweep_done", 32'(done), 32'd1);
            chk("sweep_ready_drive", 32'(in_ready), 32'd0);
            cyc();
            chk("sweep_out_clear", 32'(out), 32'h0);
        end
        in_valid = 1'b0;
        cyc();

        // Pulse of 3 then gap of 2; in_valid held so the next accept lands 6 edges later
        in_code   = 2'd2;
        pulse_len = 8'd3;
        gap_len   = 8'd2;
        in_valid  = 1'b1;
        cyc();
        pulse_len = 8'd1;
        gap_len   = 8'd0;
        for (int k = 1; k <= 3; k++) begin
            chk("pg_out", 32'(out), 32'h4);
            chk("pg_done", 32'(done), 32'(k == 3));
            chk("pg_busy", 32'(busy), 32'd1);
            cyc();
        end
        for (int k = 0; k < 2; k++) begin
            chk("gap_out", 32'(out), 32'h0);
            chk("gap_ready", 32'(in_ready), 32'd0);
            cyc();
        end
        chk("gap_end_ready", 32'(in_ready), 32'd1);
        cyc();
        chk("reaccept_out", 32'(out), 32'h4);
        chk("reaccept_done", 32'(done), 32'd1);
        in_valid = 1'b0;
        cyc();
        chk("reaccept_clear", 32'(out), 32'h0);

        // Codes presented while busy are ignored
        in_code   = 2'd1;
        pulse_len = 8'd4;
        in_valid  = 1'b1;
        cyc();
        in_code = 2'd3;
        for (int k = 0; k < 4; k++) begin
            chk("busy_hold_out", 32'(out), 32'h2);
            cyc();
        end
        chk("busy_end_out", 32'(out), 32'h0);
        chk("busy_end_ready", 32'(in_ready), 32'd1);
        pulse_len = 8'd1;
        cyc();
        chk("late_accept_out", 32'(out), 32'h8);
        chk("late_accept_done", 32'(done), 32'd1);
        in_valid = 1'b0;
        cyc();

        // Reset in the middle of a long pulse
        in_code   = 2'd0;
        pulse_len = 8'd10;
        in_valid  = 1'b1;
        cyc();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("mid_out", 32'(out), 32'h1);
            chk("mid_done", 32'(done), 32'd0);
            cyc();
        end
        rst_n = 1'b0;
        cyc();
        chk("mid_rst_out", 32'(out), 32'h0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_out", 32'(out), 32'h0);

        // pulse_len = 0 behaves as 1
        in_code   = 2'd3;
        pulse_len = 8'd0;
        gap_len   = 8'd0;
        in_valid  = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("p0_out", 32'(out), 32'h8);
        chk("p0_done", 32'(done), 32'd1);
        cyc();
        chk("p0_clear", 32'(out), 32'h0);
        chk("p0_ready", 32'(in_ready), 32'd1);

        // pulse_len = 255 must not wrap
        in_code   = 2'd1;
        pulse_len = 8'hFF;
        in_valid  = 1'b1;
        cyc();
        in_valid = 1'b0;
        n       = 0;
        ndone   = 0;
        done_at = -1;
        while (out == 4'b0010 && n < 300) begin
            if (done) begin
                ndone++;
                done_at = n;
            end
            n++;
            cyc();
        end
        chk("p255_len", 32'(n), 32'd255);
        chk("p255_done_cnt", 32'(ndone), 32'd1);
        chk("p255_done_at", 32'(done_at), 32'd254);
        chk("p255_ready", 32'(in_ready), 32'd1);

`ifdef DECODER_HIT_CNT_EN
        // Reset cleared the count; two accepts followed it
        chk("hit_two", 32'(hit_count), 32'd2);
        force dut.hit_cnt_q = 16'hFFFF;
        cyc();
        release dut.hit_cnt_q;
        cyc();
        chk("hit_preload", 32'(hit_count), 32'hFFFF);
        in_code   = 2'd2;
        pulse_len = 8'd1;
        in_valid  = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("hit_sat_out", 32'(out), 32'h4);
        chk("hit_sat", 32'(hit_count), 32'hFFFF);
        cyc();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
